puf_challenge_ctrl: RTL and testbench

Challenge sequencer and response collector for the dual-adder arbiter PUF. It accepts a challenge (adder operands plus two 125-bit PDL configuration words) over a valid/ready command port. It then repeatedly excites the PUF with a zero→challenge operand transition and samples the 32-bit arbiter output. Finally it majority-votes the samples and returns the response plus a per-bit instability mask over a valid/ready response port toward the Ethernet host interface.

---
 rtl/puf_pkg.sv | 25 ++
 rtl/puf_vote_acc.sv | 59 +++++
 rtl/puf_challenge_ctrl.sv | 163 ++++++++++++++++
 tb/tb_puf_challenge_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared widths, FSM state encoding and payload types for the arbiter-PUF challenge controller.
package puf_pkg;

    localparam int unsigned PUF_OPW  = 32;
    localparam int unsigned PUF_CFGW = 125;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        VOTE   = 3'd3,
        RESP   = 3'd4
    } puf_state_e;

    typedef struct packed {
        logic [PUF_OPW-1:0] a;
        logic [PUF_OPW-1:0] b;
    } puf_op_t;

    // A bit votes 1 when strictly more than half of the samples were 1.
    function automatic int unsigned maj_threshold(input int unsigned num_samples);
        return num_samples / 2;
    endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit sample counters with registered majority and instability vectors.
module puf_vote_acc
    import puf_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 7,
    parameter int unsigned CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               sample_en_i,
    input  logic [PUF_OPW-1:0] sample_i,
    input  logic               vote_en_i,
    output logic [PUF_OPW-1:0] maj_o,
    output logic [PUF_OPW-1:0] unstable_o
);

    logic [CNT_W-1:0]   cnt_q [PUF_OPW];
    logic [CNT_W-1:0]   cnt_d [PUF_OPW];
    logic [PUF_OPW-1:0] maj_q, maj_d;
    logic [PUF_OPW-1:0] unst_q, unst_d;

    always_comb begin
        maj_d  = maj_q;
        unst_d = unst_q;
        for (int i = 0; i < int'(PUF_OPW); i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
            end else if (sample_en_i) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(sample_i[i]);
            end
            if (vote_en_i) begin
                maj_d[i]  = (cnt_q[i] > CNT_W'(maj_threshold(NUM_SAMPLES)));
                unst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != CNT_W'(NUM_SAMPLES));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PUF_OPW); i++) begin
                cnt_q[i] <= '0;
            end
            maj_q  <= '0;
            unst_q <= '0;
        end else begin
            for (int i = 0; i < int'(PUF_OPW); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            maj_q  <= maj_d;
            unst_q <= unst_d;
        end
    end

    assign maj_o      = maj_q;
    assign unstable_o = unst_q;

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Challenge sequencer for the dual-adder arbiter PUF: repeated zero->challenge
// excitations, synchronized sampling of the arbiter output and majority voting.
module puf_challenge_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_SAMPLES   = 7,
    parameter int unsigned CNT_W         = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PUF_OPW-1:0]  cmd_a,
    input  logic [PUF_OPW-1:0]  cmd_b,
    input  logic [PUF_CFGW-1:0] cmd_config1,
    input  logic [PUF_CFGW-1:0] cmd_config2,
    output logic [PUF_OPW-1:0]  puf_a,
    output logic [PUF_OPW-1:0]  puf_b,
    output logic [PUF_CFGW-1:0] puf_config1,
    output logic [PUF_CFGW-1:0] puf_config2,
    input  logic [PUF_OPW-1:0]  puf_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [PUF_OPW-1:0]  rsp_data,
    output logic [PUF_OPW-1:0]  rsp_unstable
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned SMP_W = 8;

    puf_state_e          state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [SMP_W-1:0]    smp_q, smp_d;
    puf_op_t             op_q, op_d;
    logic [PUF_CFGW-1:0] cfg1_q, cfg1_d;
    logic [PUF_CFGW-1:0] cfg2_q, cfg2_d;
    logic [PUF_OPW-1:0]  puf_a_q, puf_a_d;
    logic [PUF_OPW-1:0]  puf_b_q, puf_b_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [PUF_OPW-1:0]  sync1_q, sync2_q;
    logic                acc_clear_c, sample_en_c, vote_en_c;
    logic                settle_last_c;

    assign settle_last_c = (settle_q == SET_W'(SETTLE_CYCLES - 1));

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        smp_d       = smp_q;
        op_d        = op_q;
        cfg1_d      = cfg1_q;
        cfg2_d      = cfg2_q;
        acc_clear_c = 1'b0;
        sample_en_c = 1'b0;
        vote_en_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d.a      = cmd_a;
                    op_d.b      = cmd_b;
                    cfg1_d      = cmd_config1;
                    cfg2_d      = cmd_config2;
                    acc_clear_c = 1'b1;
                    smp_d       = '0;
                    settle_d    = '0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                if (settle_last_c) begin
                    settle_d = '0;
                    state_d  = LAUNCH;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            LAUNCH: begin
                if (settle_last_c) begin
                    settle_d    = '0;
                    sample_en_c = 1'b1;
                    smp_d       = smp_q + SMP_W'(1);
                    state_d     = (smp_d < SMP_W'(NUM_SAMPLES)) ? CLEAR : VOTE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            VOTE: begin
                vote_en_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operands are only driven while the next cycle is a launch cycle.
        puf_a_d     = (state_d == LAUNCH) ? op_q.a : '0;
        puf_b_d     = (state_d == LAUNCH) ? op_q.b : '0;
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            smp_q       <= '0;
            op_q        <= '0;
            cfg1_q      <= '0;
            cfg2_q      <= '0;
            puf_a_q     <= '0;
            puf_b_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            smp_q       <= smp_d;
            op_q        <= op_d;
            cfg1_q      <= cfg1_d;
            cfg2_q      <= cfg2_d;
            puf_a_q     <= puf_a_d;
            puf_b_q     <= puf_b_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            sync1_q     <= puf_c;
            sync2_q     <= sync1_q;
        end
    end

    puf_vote_acc #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .CNT_W       (CNT_W)
    ) u_vote_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (acc_clear_c),
        .sample_en_i (sample_en_c),
        .sample_i    (sync2_q),
        .vote_en_i   (vote_en_c),
        .maj_o       (rsp_data),
        .unstable_o  (rsp_unstable)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign puf_a       = puf_a_q;
    assign puf_b       = puf_b_q;
    assign puf_config1 = cfg1_q;
    assign puf_config2 = cfg2_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Scoreboard bench for puf_challenge_ctrl: a PUF stub feeds queued arbiter values per launch,
// a monitor checks launches and responses against expectations computed from sample vote counts.
module tb_puf_challenge_ctrl;

    localparam int S   = 4;
    localparam int N   = 7;
    localparam int LAT = 2 * S * N + 1;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_a, cmd_b;
    logic [124:0] cmd_config1, cmd_config2;
    logic [31:0]  puf_a, puf_b;
    logic [124:0] puf_config1, puf_config2;
    logic [31:0]  puf_c;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data, rsp_unstable;

    puf_challenge_ctrl #(
        .SETTLE_CYCLES (S),
        .NUM_SAMPLES   (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_config1  (cmd_config1),
        .cmd_config2  (cmd_config2),
        .puf_a        (puf_a),
        .puf_b        (puf_b),
        .puf_config1  (puf_config1),
        .puf_config2  (puf_config2),
        .puf_c        (puf_c),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_unstable (rsp_unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] unst;
    } exp_t;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           rsp_seen = 0;
    exp_t         exp_q[$];
    logic [31:0]  stub_q[$];
    logic [31:0]  pat[N];
    logic [31:0]  cur_a = '0, cur_b = '0;
    logic [124:0] cur_c1 = '0, cur_c2 = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // PUF stub plus response monitor, all sampled on the falling edge.
    initial begin : monitor
        logic [31:0] prev_a = '0;
        logic        prev_valid = 1'b0;
        logic        hs_prev = 1'b0;
        logic [31:0] held_d = '0, held_u = '0;
        int          accept_cyc = 0;
        int          launches = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_a     = '0;
                prev_valid = 1'b0;
                hs_prev    = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("cmd_ready_after_hs", 128'(cmd_ready), 128'(1));
                    chk("rsp_valid_after_hs", 128'(rsp_valid), 128'(0));
                end
                hs_prev = rsp_valid && rsp_ready;
                if (cmd_valid && cmd_ready) begin
                    accept_cyc = cyc + 1;
                    launches   = 0;
                end
                if (puf_a != '0 && prev_a == '0) begin
                    launches++;
                    chk("launch_puf_a", 128'(puf_a), 128'(cur_a));
                    chk("launch_puf_b", 128'(puf_b), 128'(cur_b));
                    chk("launch_cfg1", 128'(puf_config1), 128'(cur_c1));
                    chk("launch_cfg2", 128'(puf_config2), 128'(cur_c2));
                    if (stub_q.size() > 0) begin
                        puf_c = stub_q.pop_front();
                    end else begin
                        chk("stub_underflow", 128'(launches), 128'(0));
                        puf_c = '0;
                    end
                end
                prev_a = puf_a;
                if (rsp_valid && !prev_valid) begin
                    rsp_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 128'(rsp_seen), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", 128'(rsp_data), 128'(e.data));
                        chk("rsp_unstable", 128'(rsp_unstable), 128'(e.unst));
                        chk("rsp_latency", 128'(cyc - accept_cyc), 128'(LAT));
                        chk("launch_count", 128'(launches), 128'(N));
                    end
                    held_d = rsp_data;
                    held_u = rsp_unstable;
                end else if (rsp_valid) begin
                    chk("rsp_data_hold", 128'(rsp_data), 128'(held_d));
                    chk("rsp_unst_hold", 128'(rsp_unstable), 128'(held_u));
                    chk("cmd_ready_in_resp", 128'(cmd_ready), 128'(0));
                end
                prev_valid = rsp_valid;
            end
        end
    end

    // Expected response from the sample list: count ones per bit, then vote.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [124:0] c1, input logic [124:0] c2);
        exp_t         e;
        logic [124:0] old_c1;
        int           ones;
        bit           done = 0;
        e.data = '0;
        e.unst = '0;
        for (int i = 0; i < 32; i++) begin
            ones = 0;
            for (int k = 0; k < N; k++) ones += int'(pat[k][i]);
            e.data[i] = (ones * 2 > N);
            e.unst[i] = (ones != 0) && (ones != N);
        end
        for (int k = 0; k < N; k++) stub_q.push_back(pat[k]);
        exp_q.push_back(e);
        old_c1      = cur_c1;
        cur_a       = a;
        cur_b       = b;
        cur_c1      = c1;
        cur_c2      = c2;
        cmd_a       = a;
        cmd_b       = b;
        cmd_config1 = c1;
        cmd_config2 = c2;
        cmd_valid   = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                chk("cfg1_before_accept", 128'(puf_config1), 128'(old_c1));
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 128'(0), 128'(1));
        @(negedge clk);
        chk("cfg1_after_accept", 128'(puf_config1), 128'(c1));
        chk("cmd_ready_after_accept", 128'(cmd_ready), 128'(0));
    endtask

    task automatic wait_hs(input bit rnd);
        bit done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) chk("hs_timeout", 128'(0), 128'(1));
        rsp_ready = 1'b1;
    endtask

    task automatic fill_pat(input logic [31:0] v);
        for (int k = 0; k < N; k++) pat[k] = v;
    endtask

    initial begin : main
        logic [31:0]  sm, sv;
        int           seen;
        bit           got;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_config1 = '0;
        cmd_config2 = '0;
        puf_c       = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_puf_a", 128'(puf_a), 128'(0));
        chk("rst_puf_b", 128'(puf_b), 128'(0));
        chk("rst_cfg1", 128'(puf_config1), 128'(0));
        chk("rst_cfg2", 128'(puf_config2), 128'(0));

        // Stable PUF, immediate acceptance of the response.
        @(posedge clk);
        #1;
        fill_pat(32'hA5A5_0F0F);
        issue(32'h1234_5678, 32'h0000_0001, {4{32'h0F0F_1234}}, {4{32'h5555_AAAA}});
        wait_hs(0);

        // Noisy PUF: bit 0 high on 4 of 7 samples, bit 1 on 3 of 7.
        pat = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2};
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, {4{32'h1357_9BDF}}, {4{32'h2468_ACE0}});
        wait_hs(0);

        // Backpressure on the response port.
        rsp_ready = 1'b0;
        fill_pat(32'h0000_FFFF);
        issue(32'hCAFE_0001, 32'h0000_0002, '1, '0);
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("bp_valid_seen", 128'(got), 128'(1));
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid_held", 128'(rsp_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_hs(0);

        // Command isolation: command port churns while a run is in flight.
        fill_pat(32'h8000_0001);
        issue(32'h0F0F_0F0F, 32'h7070_7070, {4{32'hFEED_FACE}}, {4{32'hBEEF_CAFE}});
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            cmd_a       = $urandom;
            cmd_config1 = {$urandom, $urandom, $urandom, $urandom};
            cmd_valid   = ~cmd_valid;
            @(negedge clk);
            chk("iso_cfg1", 128'(puf_config1), 128'(cur_c1));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_hs(0);

        // Back-to-back runs with config1 all zeros, then all ones.
        fill_pat(32'h1111_2222);
        issue(32'h0000_0100, 32'h0000_0200, '0, '0);
        wait_hs(0);
        fill_pat(32'h3333_4444);
        issue(32'h0000_0300, 32'h0000_0400, '1, '1);
        wait_hs(0);

        // Randomized runs: some bits forced stable, the rest random per sample.
        for (int r = 0; r < 6; r++) begin
            sm = $urandom;
            sv = $urandom;
            for (int k = 0; k < N; k++) pat[k] = (sv & sm) | ($urandom & ~sm);
            issue($urandom | 32'h1, $urandom,
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            wait_hs(1);
        end

        // Reset in the middle of a LAUNCH phase aborts the run.
        fill_pat(32'hFFFF_FFFF);
        issue(32'h5A5A_5A5A, 32'hA5A5_A5A5, '1, '1);
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = (puf_a != '0);
        end
        chk("abort_launch_seen", 128'(got), 128'(1));
        #2;
        rst_n = 1'b0;
        stub_q.delete();
        exp_q.delete();
        cur_c1 = '0;
        cur_c2 = '0;
        seen   = rsp_seen;
        @(negedge clk);
        chk("abort_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("abort_puf_a", 128'(puf_a), 128'(0));
        chk("abort_puf_b", 128'(puf_b), 128'(0));
        chk("abort_cfg1", 128'(puf_config1), 128'(0));
        chk("abort_cfg2", 128'(puf_config2), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        puf_c = '0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("abort_no_rsp", 128'(rsp_seen), 128'(seen));
        chk("abort_idle_ready", 128'(cmd_ready), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
